axis_pkt_arb_mux: RTL and testbench

- Parametrised N-to-1 AXI-Stream packet multiplexer that merges the ADC driver streams into the single PS-facing stream.
- Supports two channel-selection modes: manual (binary channel index) or round-robin among channels with valid data.
- The grant is held for a whole packet and only changes after a beat with tlast is accepted, so packets from different channels never interleave.
- The output is registered through a 2-entry skid buffer. There is no combinational path from m_axis_tready to any s_axis_tready.

---
 rtl/axis_pkt_arb_mux.sv | 177 +++++++++++++++++
 tb/tb_axis_pkt_arb_mux.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arb_mux.sv
// N-to-1 AXI-Stream packet multiplexer.
// A channel is chosen in IDLE, either by manual index or by round-robin.
// The grant then stays locked until that channel's tlast beat is accepted.
// Accepted beats go through a 2-entry skid FIFO that drives m_axis_*.
// s_axis_tready depends only on registered state, so m_axis_tready never
// reaches it combinationally.
module axis_pkt_arb_mux #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 128,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     mode_in,
    input  logic [SEL_W-1:0]         select_in,
    input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_CH-1:0]          s_axis_tvalid,
    input  logic [N_CH-1:0]          s_axis_tlast,
    output logic [N_CH-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [SEL_W-1:0]         m_axis_tid,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [SEL_W-1:0]  id;
    } beat_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;

    beat_t             mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;

    logic [DATA_W-1:0] s_data [N_CH];
    logic              cand_vld;
    logic [SEL_W-1:0]  cand;
    int                rr_idx;
    logic [SEL_W-1:0]  rr_sel;
    logic              int_ready;
    logic              push;
    logic              pop;
    beat_t             push_beat;
    beat_t             head;

    // Split the packed input bus into one data word per channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            s_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
        end
    end

    // Pick the next packet source. Out-of-range manual indices yield no
    // candidate. The round-robin search wraps modulo N_CH, not 2^SEL_W.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        cand_vld = 1'b0;
        cand     = '0;
        rr_idx   = 0;
        rr_sel   = '0;
        if (!mode_in) begin
            if ((int'(select_in) < N_CH) && s_axis_tvalid[select_in]) begin
                cand_vld = 1'b1;
                cand     = select_in;
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                rr_idx = int'(last_grant_q) + k;
                if (rr_idx >= N_CH) begin
                    rr_idx = rr_idx - N_CH;
                end
                rr_sel = SEL_W'(rr_idx);
                if (!cand_vld && s_axis_tvalid[rr_sel]) begin
                    cand_vld = 1'b1;
                    cand     = rr_sel;
                end
            end
        end
    end

    // Accept a beat from the granted channel whenever the skid FIFO has room.
    always_comb begin
        int_ready      = (count_q != 2'd2);
        push           = (state_q == LOCKED) && s_axis_tvalid[grant_q] && int_ready;
        pop            = m_axis_tvalid && m_axis_tready;
        push_beat.data = s_data[grant_q];
        push_beat.last = s_axis_tlast[grant_q];
        push_beat.id   = grant_q;
        count_d        = count_q + 2'(push) - 2'(pop);
    end

    // Arbitration FSM: choose a source in IDLE, hold it until tlast is accepted.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        s_axis_tready = '0;
        unique case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    grant_d = cand;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                s_axis_tready[grant_q] = int_ready;
                if (push && s_axis_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register the arbitration state.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples its pre-edge value no matter how the blocks are ordered.
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SEL_W'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Skid FIFO storage and pointers. Push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the two entries are reset on purpose. The head drives
        // m_axis_tdata/tid/tlast directly, and those outputs must read zero
        // while reset is held. Larger storage arrays normally stay unreset.
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // The FIFO head drives the master stream.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        m_axis_tdata  = head.data;
        m_axis_tid    = head.id;
        m_axis_tlast  = head.last;
        m_axis_tvalid = (count_q != 2'd0);
        busy          = (state_q == LOCKED);
    end

endmodule

// File: tb/tb_axis_pkt_arb_mux.sv
// Self-checking bench for axis_pkt_arb_mux.
// The reference model works at packet level. Every pending packet is queued
// per channel, and the expected output order comes straight from the
// manual / round-robin selection rules.
// N_CH = 12 is used so that select_in can hold an out-of-range channel index.
module tb_axis_pkt_arb_mux;

    localparam int N_CH   = 12;
    localparam int DATA_W = 64;
    localparam int SEL_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                ch;
    } obeat_t;

    logic                   clk;
    logic                   rstn;
    logic                   mode_in;
    logic [SEL_W-1:0]       select_in;
    logic [N_CH*DATA_W-1:0] s_axis_tdata;
    logic [N_CH-1:0]        s_axis_tvalid;
    logic [N_CH-1:0]        s_axis_tlast;
    logic [N_CH-1:0]        s_axis_tready;
    logic [DATA_W-1:0]      m_axis_tdata;
    logic [SEL_W-1:0]       m_axis_tid;
    logic                   m_axis_tlast;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   busy;

    beat_t  src_q [N_CH][$];  // beats still to be offered by each source
    beat_t  mdl_q [N_CH][$];  // the same beats, consumed by the model
    int     exp_ch[$];        // expected order of granted packets
    obeat_t exp_out[$];       // expected output beat stream
    int     occ;              // beats accepted but not yet popped
    int     mdl_last;         // model's last granted channel
    int     idle_flag;
    int     rdy_mode;
    int     rdy_phase;
    int     n_checks;
    int     n_errors;

    axis_pkt_arb_mux #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .mode_in       (mode_in),
        .select_in     (select_in),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [DATA_W-1:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? {$urandom, $urandom} : base + DATA_W'(i);
            b.last = (i == len - 1);
            src_q[ch].push_back(b);
            mdl_q[ch].push_back(b);
        end
    endtask

    // Move one whole packet of channel c into the expected output.
    task automatic take_pkt(input int c);
        beat_t  b;
        obeat_t o;
        bit     done;
        done = 1'b0;
        while (!done) begin
            b = mdl_q[c].pop_front();
            o.data = b.data;
            o.last = b.last;
            o.ch   = c;
            exp_out.push_back(o);
            done = b.last;
        end
        exp_ch.push_back(c);
        mdl_last = c;
    endtask

    // Manual mode: only the selected channel is served, if it exists.
    task automatic model_manual(input int sel);
        if (sel < N_CH) begin
            while (mdl_q[sel].size() > 0) take_pkt(sel);
        end
    endtask

    // Round-robin mode: every source keeps its valid high while it has packets,
    // so each grant goes to the next non-empty channel after the last one.
    task automatic model_rr();
        bit found;
        int c;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= N_CH; k++) begin
                c = (mdl_last + k) % N_CH;
                if (!found && mdl_q[c].size() > 0) begin
                    take_pkt(c);
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < N_CH; c++) begin
            src_q[c].delete();
            mdl_q[c].delete();
        end
        exp_ch.delete();
        exp_out.delete();
        occ       = 0;
        mdl_last  = N_CH - 1;
        idle_flag = 0;
    endtask

    task automatic drive();
        for (int c = 0; c < N_CH; c++) begin
            if (src_q[c].size() > 0) begin
                s_axis_tvalid[c]                    = 1'b1;
                s_axis_tdata[c*DATA_W +: DATA_W]    = src_q[c][0].data;
                s_axis_tlast[c]                     = src_q[c][0].last;
            end else begin
                s_axis_tvalid[c]                    = 1'b0;
                s_axis_tdata[c*DATA_W +: DATA_W]    = '0;
                s_axis_tlast[c]                     = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
        endcase
        rdy_phase++;
    endtask

    // One clock cycle. Entered and left at a negedge.
    task automatic cycle();
        logic [N_CH-1:0] acc;
        logic [N_CH-1:0] mask;
        logic            popped;
        beat_t           b;
        drive();
        #1;
        if (exp_ch.size() == 0) begin
            check("tready_none", s_axis_tready, '0);
        end else begin
            mask = '0;
            mask[exp_ch[0]] = 1'b1;
            check("tready_grant", s_axis_tready & ~mask, '0);
        end
        check("m_tvalid_occ", m_axis_tvalid, occ != 0);
        if (occ == 2) check("tready_full", s_axis_tready, '0);
        if (m_axis_tvalid && exp_out.size() > 0) begin
            check("m_tdata", m_axis_tdata, exp_out[0].data);
            check("m_tid",   m_axis_tid,   exp_out[0].ch);
            check("m_tlast", m_axis_tlast, exp_out[0].last);
        end
        if (idle_flag == 1) begin
            check("gap_busy",   busy, 1'b0);
            check("gap_tready", s_axis_tready, '0);
            idle_flag = 2;
        end else if (idle_flag == 2) begin
            check("regrant_busy", busy, 1'b1);
            idle_flag = 0;
        end
        acc    = s_axis_tvalid & s_axis_tready;
        popped = m_axis_tvalid & m_axis_tready;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < N_CH; c++) begin
            if (acc[c]) begin
                b = src_q[c].pop_front();
                check("acc_channel", c, (exp_ch.size() > 0) ? exp_ch[0] : -1);
                occ++;
                if (b.last && exp_ch.size() > 0) begin
                    void'(exp_ch.pop_front());
                    if (exp_ch.size() > 0) idle_flag = 1;
                end
            end
        end
        if (popped) begin
            check("out_beat_expected", exp_out.size() > 0, 1'b1);
            if (exp_out.size() > 0) void'(exp_out.pop_front());
            occ--;
        end
    endtask

    task automatic run_until_drained(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((exp_out.size() > 0 || exp_ch.size() > 0 || occ > 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, exp_out.size() + exp_ch.size() + occ, 0);
    endtask

    // Assert reset at a negedge, check the outputs clear at once, then release.
    task automatic apply_reset();
        rstn = 1'b0;
        #1;
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_busy",     busy, 1'b0);
        check("rst_tready",   s_axis_tready, '0);
        check("rst_m_tdata",  m_axis_tdata, '0);
        check("rst_m_tid",    m_axis_tid, '0);
        check("rst_m_tlast",  m_axis_tlast, 1'b0);
        clear_all();
        drive();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int sel;
        int n;
        n_checks      = 0;
        n_errors      = 0;
        rdy_mode      = 0;
        rdy_phase     = 0;
        mode_in       = 1'b0;
        select_in     = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        clear_all();
        rstn = 1'b0;
        #2;
        apply_reset();

        // 1: manual channel 3, 4-beat packet. A noise packet on channel 4
        // must stay unserved.
        mode_in   = 1'b0;
        select_in = 4'd3;
        add_pkt(3, 4, 64'hA0, 1'b0);
        add_pkt(4, 2, 64'hE0, 1'b0);
        model_manual(3);
        run_until_drained(50, "t1");
        apply_reset();

        // 2: round-robin over channels 0, 5 and 11. Expected order: 0, 5, 11, 0.
        mode_in = 1'b1;
        add_pkt(0, 2, 64'h100, 1'b0);
        add_pkt(0, 2, 64'h110, 1'b0);
        add_pkt(5, 2, 64'h150, 1'b0);
        add_pkt(11, 2, 64'h1B0, 1'b0);
        model_rr();
        run_until_drained(100, "t2");

        // 3: backpressure pattern 1,0,0,1 on a 6-beat packet.
        mode_in   = 1'b0;
        select_in = 4'd6;
        rdy_mode  = 2;
        rdy_phase = 0;
        add_pkt(6, 6, 64'h300, 1'b0);
        model_manual(6);
        run_until_drained(100, "t3");

        // 4: select_in moves from 3 to 7 in the middle of channel 3's packet.
        rdy_mode  = 0;
        select_in = 4'd3;
        add_pkt(3, 4, 64'h400, 1'b0);
        add_pkt(7, 3, 64'h470, 1'b0);
        model_manual(3);
        model_manual(7);
        n = 0;
        while (src_q[3].size() > 2 && n < 20) begin
            cycle();
            n++;
        end
        select_in = 4'd7;
        run_until_drained(100, "t4");

        // 5: out-of-range manual select with every channel requesting.
        select_in = 4'd12;
        for (int c = 0; c < N_CH; c++) add_pkt(c, 1, 64'h500 + 64'(c), 1'b0);
        repeat (20) begin
            cycle();
            check("t5_busy", busy, 1'b0);
        end
        mode_in = 1'b1;
        model_rr();
        run_until_drained(200, "t5");

        // 6: reset after beat 2 of a 4-beat packet, then a clean new packet.
        mode_in   = 1'b0;
        select_in = 4'd2;
        add_pkt(2, 4, 64'h600, 1'b0);
        model_manual(2);
        n = 0;
        while (src_q[2].size() > 2 && n < 20) begin
            cycle();
            n++;
        end
        apply_reset();
        mode_in   = 1'b0;
        select_in = 4'd2;
        add_pkt(2, 4, 64'h610, 1'b0);
        model_manual(2);
        run_until_drained(50, "t6");

        // Random rounds: random packets and random backpressure.
        // Each round runs a manual phase, then a round-robin drain.
        rdy_mode = 1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    add_pkt(c, $urandom_range(1, 5), '0, 1'b1);
                    if ($urandom_range(0, 1) == 1) add_pkt(c, $urandom_range(1, 5), '0, 1'b1);
                end
            end
            sel       = $urandom_range(0, N_CH - 1);
            mode_in   = 1'b0;
            select_in = SEL_W'(sel);
            model_manual(sel);
            run_until_drained(400, "rnd_man");
            mode_in = 1'b1;
            model_rr();
            run_until_drained(800, "rnd_rr");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
